// File: rtl/systolic_result_drain_pkg.sv
// Shared definitions for the systolic result drain and the array top.
//   drain_state_t : drain controller state encoding
//   cap_lat()     : cycles from first operand beat to accumulator capture
//   elem_lsb()    : LSB of element (i,j) in the flattened C vector
package systolic_result_drain_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } drain_state_t;

   // Beat k reaches PE(i,j) at cycle k+i+j; the last product lands after
   // cycle 3N-3, so the snapshot is taken during cycle 3N-2.
   function automatic int cap_lat(input int n);
      return 3 * n - 2;
   endfunction

   // Element (i,j) occupies [(i*n+j+1)*ew-1 -: ew] of the flattened C vector.
   function automatic int elem_lsb(input int i, input int j, input int n, input int ew);
      return (i * n + j) * ew;
   endfunction

endpackage

// File: rtl/systolic_row_buffer.sv
// Capture registers for the full N_SIZE x N_SIZE result matrix.
//   clk, rst   : clock, async active-high reset (clears the buffer)
//   i_load     : parallel load of all accumulators from i_c_flat
//   i_c_flat   : flattened accumulator vector from the array
//   i_row_sel  : row to present on o_row
//   o_row      : selected row, element j at [(j+1)*2*DATAWIDTH-1 -: 2*DATAWIDTH]
module systolic_row_buffer
   import systolic_result_drain_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int N_SIZE    = 3,
   parameter int SELW      = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 i_load,
   input  logic [N_SIZE*N_SIZE*2*DATAWIDTH-1:0] i_c_flat,
   input  logic [SELW-1:0]                      i_row_sel,
   output logic [N_SIZE*2*DATAWIDTH-1:0]        o_row
);

   localparam int EW = 2 * DATAWIDTH;
   localparam int RW = N_SIZE * EW;

   logic [RW-1:0] r_rows [N_SIZE];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_SIZE; i++) r_rows[i] <= '0;
      end else if (i_load) begin
         for (int i = 0; i < N_SIZE; i++)
            for (int j = 0; j < N_SIZE; j++)
               r_rows[i][j*EW +: EW] <= i_c_flat[elem_lsb(i, j, N_SIZE, EW) +: EW];
      end
   end

   always_comb begin
      o_row = '0;
      for (int i = 0; i < N_SIZE; i++)
         if (i_row_sel == SELW'(i)) o_row = r_rows[i];
   end

endmodule

// File: rtl/systolic_result_drain.sv
// Result drain for an output-stationary N_SIZE x N_SIZE systolic array.
// Follows the operand feed, waits out the skew, snapshots all accumulators,
// clears the array and streams C row by row on a valid/ready port.
//   clk, rst   : clock, async active-high reset
//   valid_in   : operand beat strobe shared with the array
//   c_flat     : flattened array accumulators
//   in_ready   : a new matrix pair may be fed
//   acc_clr    : one-cycle accumulator clear to the array
//   m_valid/m_ready/m_data/m_last : result row stream
//   feed_err   : sticky illegal-feed flag
//
// state | meaning
// IDLE  | waiting for the first operand beat
// FEED  | counting operand beats, gap is an error
// WAIT  | waiting for the skew latency to expire
// DRAIN | presenting captured rows to the consumer
module systolic_result_drain
   import systolic_result_drain_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int N_SIZE    = 3
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 valid_in,
   input  logic [N_SIZE*N_SIZE*2*DATAWIDTH-1:0] c_flat,
   output logic                                 in_ready,
   output logic                                 acc_clr,
   output logic                                 m_valid,
   input  logic                                 m_ready,
   output logic [N_SIZE*2*DATAWIDTH-1:0]        m_data,
   output logic                                 m_last,
   output logic                                 feed_err
);

   localparam int CW = $clog2(3 * N_SIZE);
   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [CW-1:0] C_N    = CW'(N_SIZE);
   localparam logic [CW-1:0] C_LAST = CW'(N_SIZE - 1);
   localparam logic [CW-1:0] C_CAP  = CW'(cap_lat(N_SIZE));

   drain_state_t   r_state, w_state_nxt;
   logic [CW-1:0]  r_beat_cnt, w_beat_cnt_nxt;
   logic [CW-1:0]  r_lat_cnt, w_lat_cnt_nxt;
   logic [CW-1:0]  r_row_idx, w_row_idx_nxt;
   logic           r_feed_err, w_feed_err_nxt;
   logic           r_acc_clr, w_acc_clr_nxt;
   logic           w_load;
   logic [N_SIZE*2*DATAWIDTH-1:0] w_row;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_beat_cnt <= '0;
         r_lat_cnt  <= '0;
         r_row_idx  <= '0;
         r_feed_err <= 1'b0;
         r_acc_clr  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
         r_lat_cnt  <= w_lat_cnt_nxt;
         r_row_idx  <= w_row_idx_nxt;
         r_feed_err <= w_feed_err_nxt;
         r_acc_clr  <= w_acc_clr_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_beat_cnt_nxt = r_beat_cnt;
      w_lat_cnt_nxt  = r_lat_cnt;
      w_row_idx_nxt  = r_row_idx;
      w_feed_err_nxt = r_feed_err;
      w_acc_clr_nxt  = 1'b0;
      w_load         = 1'b0;
      case (r_state)
         IDLE: begin
            if (valid_in) begin
               w_beat_cnt_nxt = C_ONE;
               w_lat_cnt_nxt  = C_ONE;
               w_state_nxt    = (N_SIZE == 1) ? WAIT : FEED;
            end
         end
         FEED: begin
            w_lat_cnt_nxt = r_lat_cnt + C_ONE;
            if (valid_in) begin
               w_beat_cnt_nxt = r_beat_cnt + C_ONE;
               if (r_beat_cnt + C_ONE == C_N) w_state_nxt = WAIT;
            end else begin
               // Broken feed: abandon this matrix and scrub partial sums.
               w_feed_err_nxt = 1'b1;
               w_acc_clr_nxt  = 1'b1;
               w_beat_cnt_nxt = '0;
               w_lat_cnt_nxt  = '0;
               w_state_nxt    = IDLE;
            end
         end
         WAIT: begin
            w_lat_cnt_nxt = r_lat_cnt + C_ONE;
            if (valid_in) w_feed_err_nxt = 1'b1;
            if (r_lat_cnt == C_CAP) begin
               // Snapshot and clear share this edge; the array sees the
               // clear on the next edge, so the buffer keeps pre-clear sums.
               w_load         = 1'b1;
               w_acc_clr_nxt  = 1'b1;
               w_beat_cnt_nxt = '0;
               w_lat_cnt_nxt  = '0;
               w_row_idx_nxt  = '0;
               w_state_nxt    = DRAIN;
            end
         end
         DRAIN: begin
            if (valid_in) w_feed_err_nxt = 1'b1;
            if (m_ready) begin
               if (r_row_idx == C_LAST) begin
                  w_row_idx_nxt = '0;
                  w_state_nxt   = IDLE;
               end else begin
                  w_row_idx_nxt = r_row_idx + C_ONE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   systolic_row_buffer #(
      .DATAWIDTH (DATAWIDTH),
      .N_SIZE    (N_SIZE),
      .SELW      (CW)
   ) u_row_buffer (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_c_flat  (c_flat),
      .i_row_sel (r_row_idx),
      .o_row     (w_row)
   );

   assign in_ready = (r_state == IDLE) || ((r_state == FEED) && (r_beat_cnt < C_LAST));
   assign acc_clr  = r_acc_clr;
   assign m_valid  = (r_state == DRAIN);
   assign m_data   = m_valid ? w_row : '0;
   assign m_last   = m_valid && (r_row_idx == C_LAST);
   assign feed_err = r_feed_err;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: a behavioural 3x3 output-stationary array
// drives c_flat, directed matrix pairs are fed, and a scoreboard checks rows.
module tb_systolic_result_drain;

   localparam int DW = 8;
   localparam int N  = 3;
   localparam int EW = 2 * DW;

   logic clk = 1'b0;
   logic rst;
   logic valid_in = 1'b0;
   logic m_ready  = 1'b1;
   logic [N*N*EW-1:0] c_flat;
   logic in_ready, acc_clr, m_valid, m_last, feed_err;
   logic [N*EW-1:0] m_data;

   systolic_result_drain #(.DATAWIDTH(DW), .N_SIZE(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .valid_in (valid_in),
      .c_flat   (c_flat),
      .in_ready (in_ready),
      .acc_clr  (acc_clr),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_last   (m_last),
      .feed_err (feed_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   // ---------------- behavioural array ----------------
   logic [7:0]  ma [9];
   logic [7:0]  mb [9];
   logic [15:0] acc [N][N];
   logic [15:0] s;
   int  cyc;
   int  bcnt;
   int  fc [N];
   bit  fv [N];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc  <= 0;
         bcnt <= 0;
         for (int k = 0; k < N; k++) begin
            fv[k] <= 1'b0;
            fc[k] <= 0;
         end
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) acc[i][j] <= '0;
      end else begin
         cyc <= cyc + 1;
         if (acc_clr) begin
            bcnt <= 0;
            for (int k = 0; k < N; k++) fv[k] <= 1'b0;
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++) acc[i][j] <= '0;
         end else begin
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++) begin
                  s = acc[i][j];
                  for (int k = 0; k < N; k++)
                     if ((fv[k] && (cyc == fc[k] + i + j)) ||
                         (valid_in && (k == bcnt) && (i + j == 0)))
                        s = s + 16'(ma[i*N+k]) * 16'(mb[k*N+j]);
                  acc[i][j] <= s;
               end
            if (valid_in && (bcnt < N)) begin
               fc[bcnt] <= cyc;
               fv[bcnt] <= 1'b1;
               bcnt     <= bcnt + 1;
            end
         end
      end
   end

   always_comb begin
      c_flat = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) c_flat[(i*N+j)*EW +: EW] = acc[i][j];
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [N*EW-1:0] d;
      logic            l;
   } row_t;
   row_t exp_q [$];

   task automatic push_row(input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic l);
      row_t r;
      r.d = {e2, e1, e0};
      r.l = l;
      exp_q.push_back(r);
   endtask

   always @(negedge clk) begin
      if (!rst && m_valid) begin
         check("row_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            check("m_data", 64'(m_data), 64'(exp_q[0].d));
            check("m_last", 64'(m_last), 64'(exp_q[0].l));
            if (m_ready) void'(exp_q.pop_front());
         end
      end
   end

   int clr_cnt = 0;
   always @(negedge clk) if (acc_clr) clr_cnt++;

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int nb);
      for (int k = 0; k < nb; k++) begin
         check("in_ready_beat", 64'(in_ready), 64'(k < N - 1));
         valid_in = 1'b1;
         tick();
      end
      valid_in = 1'b0;
   endtask

   task automatic wait_drain();
      bit done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         if (exp_q.size() == 0 && !m_valid) done = 1'b1;
         else tick();
      end
      check("drain_done", 64'(done), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_acc_clr"},  64'(acc_clr),  64'd0);
      check({tag, "_m_valid"},  64'(m_valid),  64'd0);
      check({tag, "_m_data"},   64'(m_data),   64'd0);
      check({tag, "_m_last"},   64'(m_last),   64'd0);
      check({tag, "_feed_err"}, 64'(feed_err), 64'd0);
   endtask

   task automatic set_b_identity();
      mb = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  c0;
      bit  seen;
      ma = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      mb = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      rst = 1'b0;
      #1 rst = 1'b1;
      #2 check_reset_outputs("reset");
      tick();
      rst = 1'b0;
      tick();

      // A = 1..9, B = I: capture timing and basic drain
      ma = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
      set_b_identity();
      push_row(16'd1, 16'd2, 16'd3, 1'b0);
      push_row(16'd4, 16'd5, 16'd6, 1'b0);
      push_row(16'd7, 16'd8, 16'd9, 1'b1);
      c0 = clr_cnt;
      feed(3);
      repeat (4) tick();
      check("pre_capture_valid", 64'(m_valid), 64'd0);
      check("pre_capture_clr",   64'(acc_clr), 64'd0);
      tick();
      check("capture_valid", 64'(m_valid), 64'd1);
      check("capture_clr",   64'(acc_clr), 64'd1);
      wait_drain();
      check("clr_once", 64'(clr_cnt - c0), 64'd1);

      // Backpressure: B = diag(1,2,3)
      mb = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd3};
      push_row(16'd1, 16'd4,  16'd9,  1'b0);
      push_row(16'd4, 16'd10, 16'd18, 1'b0);
      push_row(16'd7, 16'd16, 16'd27, 1'b1);
      m_ready = 1'b0;
      feed(3);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (m_valid) seen = 1'b1;
         else tick();
      end
      check("bp_valid_seen", 64'(seen), 64'd1);
      repeat (5) tick();
      check("bp_hold_valid", 64'(m_valid), 64'd1);
      for (int t = 0; t < 12 && exp_q.size() != 0; t++) begin
         m_ready = (t % 2 == 0);
         tick();
      end
      m_ready = 1'b1;
      wait_drain();

      // Feed gap after beat 2
      c0 = clr_cnt;
      feed(2);
      tick();
      check("gap_feed_err", 64'(feed_err), 64'd1);
      check("gap_acc_clr",  64'(acc_clr),  64'd1);
      check("gap_in_ready", 64'(in_ready), 64'd1);
      check("gap_m_valid",  64'(m_valid),  64'd0);
      tick();
      check("gap_clr_pulse_end", 64'(acc_clr), 64'd0);
      repeat (8) tick();
      check("gap_clr_once", 64'(clr_cnt - c0), 64'd1);
      check("gap_no_valid", 64'(m_valid), 64'd0);
      ma = '{8'd2, 8'd0, 8'd1, 8'd3, 8'd1, 8'd4, 8'd0, 8'd5, 8'd2};
      set_b_identity();
      push_row(16'd2, 16'd0, 16'd1, 1'b0);
      push_row(16'd3, 16'd1, 16'd4, 1'b0);
      push_row(16'd0, 16'd5, 16'd2, 1'b1);
      feed(3);
      wait_drain();
      check("feed_err_sticky", 64'(feed_err), 64'd1);

      // Back-to-back: all 255 (3*65025 wraps to 64003), then ones x 1..9
      ma = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
      mb = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
      push_row(16'd64003, 16'd64003, 16'd64003, 1'b0);
      push_row(16'd64003, 16'd64003, 16'd64003, 1'b0);
      push_row(16'd64003, 16'd64003, 16'd64003, 1'b1);
      feed(3);
      repeat (8) tick();
      check("b2b_valid_drop", 64'(m_valid),  64'd0);
      check("b2b_in_ready",   64'(in_ready), 64'd1);
      ma = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
      mb = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
      push_row(16'd12, 16'd15, 16'd18, 1'b0);
      push_row(16'd12, 16'd15, 16'd18, 1'b0);
      push_row(16'd12, 16'd15, 16'd18, 1'b1);
      feed(3);
      wait_drain();

      // Reset in the middle of the drain, at row 1
      ma = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      set_b_identity();
      push_row(16'd9, 16'd8, 16'd7, 1'b0);
      push_row(16'd6, 16'd5, 16'd4, 1'b0);
      push_row(16'd3, 16'd2, 16'd1, 1'b1);
      feed(3);
      repeat (5) tick();
      check("rst_drain_valid", 64'(m_valid), 64'd1);
      tick();
      check("rst_pre_row1", 64'(m_data), 64'({16'd4, 16'd5, 16'd6}));
      rst = 1'b1;
      exp_q.delete();
      #1 check_reset_outputs("midrst");
      #1 rst = 1'b0;
      tick();
      ma = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
      push_row(16'd1, 16'd2, 16'd3, 1'b0);
      push_row(16'd4, 16'd5, 16'd6, 1'b0);
      push_row(16'd7, 16'd8, 16'd9, 1'b1);
      feed(3);
      wait_drain();

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
